button_event_gen: RTL and testbench

//  Consumes the debounced, synchronised button levels and converts them into discrete events.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/button_event_channel.sv | 93 +++++++++
 rtl/button_event_gen.sv | 36 +++
 tb/tb_button_event_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the button event path: per-channel FSM
// states, canonical channel indices and a small elaboration-time helper.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESSED,
        BTN_REPEATING
    } btn_state_t;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;

    function automatic int unsigned btn_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_channel.sv
// One button channel: edge detection, IDLE/PRESSED/REPEATING FSM and the
// hold/repeat counter, with every output registered.
module button_event_channel
    import btn_pkg::*;
#(
    parameter int unsigned HOLD_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic press,
    output logic release_p,
    output logic repeat_p,
    output logic held
);

    localparam int unsigned CW = $clog2(btn_max(HOLD_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CW-1:0] HOLD_MATCH   = CW'(HOLD_DELAY);
    localparam logic [CW-1:0] REPEAT_MATCH = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic          prev;
    logic          rise;
    logic          fall;

    assign rise = level & ~prev;
    assign fall = ~level & prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= BTN_IDLE;
            cnt       <= '0;
            prev      <= 1'b0;
            press     <= 1'b0;
            release_p <= 1'b0;
            repeat_p  <= 1'b0;
            held      <= 1'b0;
        end else begin
            prev      <= level;
            press     <= 1'b0;
            release_p <= 1'b0;
            repeat_p  <= 1'b0;
            case (state)
                BTN_IDLE: begin
                    if (rise) begin
                        state <= BTN_PRESSED;
                        cnt   <= CNT_ONE;
                        press <= 1'b1;
                        held  <= 1'b1;
                    end
                end
                BTN_PRESSED: begin
                    // Release takes priority over a coincident count match.
                    if (fall) begin
                        state     <= BTN_IDLE;
                        cnt       <= '0;
                        release_p <= 1'b1;
                        held      <= 1'b0;
                    end else if (cnt == HOLD_MATCH) begin
                        state    <= BTN_REPEATING;
                        cnt      <= CNT_ONE;
                        repeat_p <= REPEAT_EN;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BTN_REPEATING: begin
                    if (fall) begin
                        state     <= BTN_IDLE;
                        cnt       <= '0;
                        release_p <= 1'b1;
                        held      <= 1'b0;
                    end else if (cnt == REPEAT_MATCH) begin
                        cnt      <= CNT_ONE;
                        repeat_p <= REPEAT_EN;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BTN_IDLE;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_gen.sv
// Converts debounced button levels into press/release/auto-repeat pulses.
// The release pulse port is release_p because "release" is a reserved word.
module button_event_gen
    import btn_pkg::*;
#(
    parameter int unsigned N_BUTTONS     = 4,
    parameter int unsigned HOLD_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] level,
    output logic [N_BUTTONS-1:0] press,
    output logic [N_BUTTONS-1:0] release_p,
    output logic [N_BUTTONS-1:0] repeat_p,
    output logic [N_BUTTONS-1:0] held
);

    for (genvar i = 0; i < int'(N_BUTTONS); i++) begin : g_chan
        button_event_channel #(
            .HOLD_DELAY   (HOLD_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .REPEAT_EN    (REPEAT_EN)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .level    (level[i]),
            .press    (press[i]),
            .release_p(release_p[i]),
            .repeat_p (repeat_p[i]),
            .held     (held[i])
        );
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench for button_event_gen: a driver pushes the expected outputs
// of every edge from a hold-time reference model, a monitor pops and compares.
module tb_button_event_gen;
    import btn_pkg::*;

    localparam int unsigned N  = 2;
    localparam int unsigned HD = 4;
    localparam int unsigned RP = 3;

    typedef struct packed {
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] rep;
        logic [N-1:0] held;
    } ev_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] level = '0;
    logic [N-1:0] press;
    logic [N-1:0] release_p;
    logic [N-1:0] repeat_p;
    logic [N-1:0] held;

    int checks   = 0;
    int failures = 0;
    ev_t exp_q[$];

    // Reference model state: time since press, not a state machine.
    int unsigned edge_n = 0;
    bit          m_prev [N];
    bit          m_hold [N];
    int unsigned m_t0   [N];

    button_event_gen #(
        .N_BUTTONS    (N),
        .HOLD_DELAY   (HD),
        .REPEAT_PERIOD(RP),
        .REPEAT_EN    (1'b1)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .level    (level),
        .press    (press),
        .release_p(release_p),
        .repeat_p (repeat_p),
        .held     (held)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, edge_n, got, want);
        end
    endtask

    task automatic model_step(input logic [N-1:0] lvl, input logic rst, output ev_t e);
        e = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rst) begin
                m_prev[i] = 1'b0;
                m_hold[i] = 1'b0;
            end else begin
                if (lvl[i] && !m_prev[i]) begin
                    e.press[i] = 1'b1;
                    m_hold[i]  = 1'b1;
                    m_t0[i]    = edge_n;
                end else if (!lvl[i] && m_prev[i]) begin
                    e.rel[i]  = 1'b1;
                    m_hold[i] = 1'b0;
                end else if (m_hold[i]) begin
                    int unsigned t;
                    t = edge_n - m_t0[i];
                    e.rep[i] = (t >= HD) && (((t - HD) % RP) == 0);
                end
                m_prev[i] = lvl[i];
                e.held[i] = m_hold[i];
            end
        end
        edge_n++;
    endtask

    // Drive inputs for the next rising edge and queue its expected outputs.
    task automatic cyc(input logic [N-1:0] lvl, input logic rst);
        ev_t e;
        logic was_rst;
        @(negedge clock);
        was_rst = reset;
        level = lvl;
        reset = rst;
        model_step(lvl, rst, e);
        exp_q.push_back(e);
        if (rst && !was_rst) begin
            #1;
            check("async_reset_press", press, '0);
            check("async_reset_held", held, '0);
        end
    endtask

    task automatic run(input logic [N-1:0] lvl, input int n);
        for (int j = 0; j < n; j++) cyc(lvl, 1'b0);
    endtask

    always @(posedge clock) begin
        ev_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("press", press, e.press);
            check("release", release_p, e.rel);
            check("repeat_p", repeat_p, e.rep);
            check("held", held, e.held);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] lvl;
        for (int j = 0; j < 3; j++) cyc('0, 1'b1);
        // Idle after reset
        run('0, 20);
        // Short press
        run(2'b01, 2);
        run('0, 4);
        // Long hold through several repeats
        run(2'b01, 14);
        run('0, 4);
        // Release coinciding with the second repeat match
        run(2'b01, 7);
        run('0, 4);
        // Channel 1 offset by two cycles
        for (int j = 0; j < 14; j++) begin
            lvl[BTN_UP]   = (j < 10);
            lvl[BTN_DOWN] = (j >= 2 && j < 12);
            cyc(lvl, 1'b0);
        end
        run('0, 4);
        // Reset in the middle of a hold, level kept high
        run(2'b01, 5);
        for (int j = 0; j < 3; j++) cyc(2'b01, 1'b1);
        run(2'b01, 10);
        run('0, 4);
        // Randomised levels with slow toggling and rare resets
        lvl = '0;
        for (int j = 0; j < 400; j++) begin
            for (int unsigned i = 0; i < N; i++)
                if ($urandom_range(5) == 0) lvl[i] = ~lvl[i];
            cyc(lvl, $urandom_range(99) == 0);
        end
        run('0, 4);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected events left, need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
